multiply_by_n: RTL and testbench
================================

MULTIPLY_BY_N -- requirements
Module: multiply_by_n

Interface
REQ-001 SHALL have parameter: DWIDTH, 32, width of multiplicand and product.
REQ-002 SHALL have parameter: MULTIPLIER, 43, constant multiplier, a positive integer (at least 1).
REQ-003 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port: i_multiplicand  input  DWIDTH  unsigned operand, sampled only when accepted.
REQ-006 SHALL have port: i_multiplicand_v  input  1  operand valid, single-cycle request.
REQ-007 SHALL have port: o_busy  output  1  high while an operation is in progress; operand not accepted.
REQ-008 SHALL have port: o_product  output  DWIDTH  result, saturated.
REQ-009 SHALL have port: o_product_v  output  1  one-cycle result strobe.
REQ-010 SHALL have port: o_overflow  output  1  true product exceeded 2^DWIDTH-1; valid with o_product_v and held.

Function
REQ-011 SHALL define MWIDTH as the bit count of MULTIPLIER (6 for 43); iteration count is MWIDTH.
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 IDLE: if i_multiplicand_v=1 at an edge, SHALL latch the operand, clear the accumulator, set bit index 0, go to RUN, and raise o_busy.
REQ-014 RUN: at each edge, SHALL add (operand << index) to the accumulator if MULTIPLIER bit[index]=1, then increment the index.
REQ-015 RUN SHALL exit to DONE after the edge that processes bit MWIDTH-1.
REQ-016 Accumulator SHALL be DWIDTH+MWIDTH bits wide; no intermediate overflow is allowed.
REQ-017 DONE: SHALL drive o_product_v=1 for exactly one cycle, then return to IDLE at the next edge.
REQ-018 Latency: if the operand is accepted at edge E0, o_product_v SHALL be high in the cycle after edge E0+MWIDTH+1 (E0+7 for 43).
REQ-019 If accumulator > 2^DWIDTH-1: o_product SHALL be all ones and o_overflow=1; otherwise o_product SHALL equal the accumulator low DWIDTH bits and o_overflow=0.
REQ-020 o_product and o_overflow SHALL update only on the transition into DONE and hold until the next result.
REQ-021 o_busy SHALL be high in RUN and DONE, and low only in IDLE.
REQ-022 i_multiplicand_v while o_busy=1 SHALL be ignored (dropped, no queuing), with no effect on the current result.
REQ-023 Back-to-back: a request in the first IDLE cycle after DONE SHALL be accepted; the maximum rate is one operation per MWIDTH+2 cycles.
REQ-024 Operand 0 or the maximum operand SHALL need no special-case timing; latency is constant.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, o_busy=0, o_product_v=0, o_product=0, o_overflow=0, accumulator=0, index=0.
REQ-026 Reset asserted mid-RUN SHALL abort the operation with no o_product_v afterward; the first request after deassertion SHALL be handled normally.
REQ-027 Reset deassertion SHALL take effect at the next rising edge; no request is accepted on the deassertion edge itself.

Structure
REQ-028 A shared package SHALL hold the state encoding constants (IDLE, RUN, DONE) and the bit-width function used for MWIDTH, reused by divide_by_n users.
REQ-029 The block SHALL have no sub-module; FSM, accumulator and saturation logic reside in multiply_by_n.

Verification
REQ-030 Bench SHALL cover: operand 0 -> o_product=0, o_overflow=0, o_product_v exactly 7 cycles after the accepting edge.
REQ-031 Bench SHALL cover: operand 1 -> 43; operand 1000000 -> 43000000; no overflow.
REQ-032 Bench SHALL cover: operand 32'hFFFFFFFF -> o_product=32'hFFFFFFFF, o_overflow=1; operand 99882960 -> 4294967280, o_overflow=0.
REQ-033 Bench SHALL cover: operand 5 accepted, then operand 9 with valid 2 cycles later -> single result 215; the 9 is dropped.
REQ-034 Bench SHALL cover: rst_n pulsed low 3 cycles after accepting operand 7 -> no o_product_v, outputs 0; a following request of 2 -> 86.
REQ-035 Bench SHALL cover: sweep 0..1000000 back-to-back, each result compared exactly against operand*43 (saturated).

Source files
------------

// File: rtl/multiply_by_n_pkg.sv
// ============================================================================
// multiply_by_n_pkg
// Shared FSM state encoding and bit-width helper for the constant-coefficient
// sequential arithmetic blocks (multiply_by_n, divide_by_n).
// Revision: 1.0
// ============================================================================
`default_nettype none

package multiply_by_n_pkg;

    // Operation sequencing states shared by the shift-and-add / shift-and-subtract blocks
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of bits needed to represent value (position of the highest set bit + 1).
    // Returns 0 for value 0.
    function automatic int bit_width(input int unsigned value);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if ((value >> i) != 0) begin
                n = i + 1;
            end
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/multiply_by_n.sv
// ============================================================================
// multiply_by_n
// Sequential shift-and-add multiplier by a constant MULTIPLIER. One multiplier
// bit is processed per clock; the result saturates to all ones when the true
// product does not fit in DWIDTH bits, with o_overflow flagging that case.
// Revision: 1.0
// ============================================================================
`default_nettype none

module multiply_by_n
    import multiply_by_n_pkg::*;
#(
    parameter int DWIDTH     = 32,
    parameter int MULTIPLIER = 43
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DWIDTH-1:0] i_multiplicand,
    input  logic              i_multiplicand_v,
    output logic              o_busy,
    output logic [DWIDTH-1:0] o_product,
    output logic              o_product_v,
    output logic              o_overflow
);

    // Iteration count equals the number of significant multiplier bits
    localparam int MWIDTH = bit_width(MULTIPLIER);
    // Accumulator is wide enough that operand * MULTIPLIER can never wrap
    localparam int AWIDTH = DWIDTH + MWIDTH;
    localparam int IWIDTH = bit_width(MWIDTH);

    localparam logic [MWIDTH-1:0] MULT_BITS  = MULTIPLIER[MWIDTH-1:0];
    localparam logic [IWIDTH-1:0] LAST_INDEX = IWIDTH'(MWIDTH - 1);

    state_t              state;
    state_t              state_nx;
    logic [DWIDTH-1:0]   operand;
    logic [DWIDTH-1:0]   operand_nx;
    logic [AWIDTH-1:0]   acc;
    logic [AWIDTH-1:0]   acc_nx;
    logic [IWIDTH-1:0]   index;
    logic [IWIDTH-1:0]   index_nx;
    logic                finish;
    logic                sat_overflow;
    logic [DWIDTH-1:0]   sat_product;

    // State register and iteration datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            operand <= '0;
            acc     <= '0;
            index   <= '0;
        end else begin
            state   <= state_nx;
            operand <= operand_nx;
            acc     <= acc_nx;
            index   <= index_nx;
        end
    end

    // Next-state, operand capture and shift-and-add step
    always_comb begin
        state_nx   = state;
        operand_nx = operand;
        acc_nx     = acc;
        index_nx   = index;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (i_multiplicand_v) begin
                    operand_nx = i_multiplicand;
                    acc_nx     = '0;
                    index_nx   = '0;
                    state_nx   = RUN;
                end
            end
            RUN: begin
                if (MULT_BITS[index]) begin
                    acc_nx = acc + ({{MWIDTH{1'b0}}, operand} << index);
                end
                index_nx = index + IWIDTH'(1);
                if (index == LAST_INDEX) begin
                    state_nx = DONE;
                    finish   = 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Saturation of the final accumulator value feeding the result registers
    always_comb begin
        sat_overflow = |acc_nx[AWIDTH-1:DWIDTH];
        sat_product  = sat_overflow ? {DWIDTH{1'b1}} : acc_nx[DWIDTH-1:0];
    end

    // Result registers load only when entering DONE and hold until the next result;
    // the strobe is registered off DONE so it appears in the cycle after DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_product   <= '0;
            o_overflow  <= 1'b0;
            o_product_v <= 1'b0;
        end else begin
            if (finish) begin
                o_product  <= sat_product;
                o_overflow <= sat_overflow;
            end
            o_product_v <= (state == DONE);
        end
    end

    assign o_busy = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_multiply_by_n.sv
// ============================================================================
// tb_multiply_by_n
// Scoreboard bench: the driver predicts acceptance and the saturated product
// from arithmetic; a monitor pops predictions whenever o_product_v is seen.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multiply_by_n;

    localparam int DWIDTH     = 32;
    localparam int MULTIPLIER = 43;
    localparam int LATENCY    = 7;   // accepting edge to strobe-visible edge
    localparam int PERIOD_OPS = 8;   // minimum spacing of accepted requests

    typedef struct {
        logic [DWIDTH-1:0] product;
        logic              ovf;
        int                due;
        logic [DWIDTH-1:0] operand;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DWIDTH-1:0] multiplicand = '0;
    logic              multiplicand_v = 1'b0;
    logic              busy;
    logic [DWIDTH-1:0] product;
    logic              product_v;
    logic              overflow;

    int   cycle = 0;
    int   compared = 0;
    int   mismatched = 0;
    int   free_edge = 0;   // earliest edge number at which a request is accepted
    exp_t q[$];

    multiply_by_n #(
        .DWIDTH    (DWIDTH),
        .MULTIPLIER(MULTIPLIER)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_multiplicand  (multiplicand),
        .i_multiplicand_v(multiplicand_v),
        .o_busy          (busy),
        .o_product       (product),
        .o_product_v     (product_v),
        .o_overflow      (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Reference: true product with saturation to DWIDTH bits
    function automatic exp_t model(input logic [DWIDTH-1:0] op, input int due);
        exp_t e;
        longint unsigned full;
        longint unsigned maxv;
        full = longint'(op) * longint'(MULTIPLIER);
        maxv = (64'd1 << DWIDTH) - 64'd1;
        e.operand = op;
        e.due     = due;
        e.ovf     = (full > maxv);
        e.product = e.ovf ? {DWIDTH{1'b1}} : full[DWIDTH-1:0];
        return e;
    endfunction

    task automatic check(input string name, input longint unsigned act, input longint unsigned req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cycle);
        end
    endtask

    // One clock of stimulus: check busy against the model, then present inputs
    task automatic drive(input logic v, input logic [DWIDTH-1:0] d);
        @(negedge clk);
        check("busy", longint'(busy), longint'((cycle + 1) < free_edge));
        multiplicand   = d;
        multiplicand_v = v;
        if (v && (cycle + 1) >= free_edge) begin
            q.push_back(model(d, cycle + 1 + LATENCY));
            free_edge = cycle + 1 + PERIOD_OPS;
        end
    endtask

    task automatic op(input logic [DWIDTH-1:0] d);
        drive(1'b1, d);
        for (int i = 0; i < PERIOD_OPS - 1; i++) drive(1'b0, '0);
    endtask

    // Monitor: compare every strobe against the oldest prediction
    always @(negedge clk) begin
        if (product_v) begin
            if (q.size() == 0) begin
                check("unexpected_strobe", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("product", longint'(product), longint'(e.product));
                check("overflow", longint'(overflow), longint'(e.ovf));
                check("latency", longint'(cycle), longint'(e.due));
            end
        end else if (q.size() > 0 && cycle >= q[0].due) begin
            check("missing_strobe", 64'd0, 64'd1);
            void'(q.pop_front());
        end
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", longint'(busy), 0);
        check("rst_product", longint'(product), 0);
        check("rst_overflow", longint'(overflow), 0);
        check("rst_product_v", longint'(product_v), 0);
        @(negedge clk);
        rst_n = 1'b1;
        free_edge = cycle + 1;

        // Directed corner operands
        op(32'd0);
        op(32'd1);
        op(32'd1000000);
        op(32'hFFFFFFFF);
        op(32'd99882960);

        // Request during busy is dropped: only 5*43 must appear
        drive(1'b1, 32'd5);
        drive(1'b0, '0);
        drive(1'b1, 32'd9);
        for (int i = 0; i < PERIOD_OPS; i++) drive(1'b0, '0);

        // Reset in mid-operation aborts it
        drive(1'b1, 32'd7);
        drive(1'b0, '0);
        drive(1'b0, '0);
        drive(1'b0, '0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        check("abort_busy", longint'(busy), 0);
        check("abort_product", longint'(product), 0);
        check("abort_overflow", longint'(overflow), 0);
        check("abort_product_v", longint'(product_v), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        free_edge = cycle + 1;
        for (int i = 0; i < 10; i++) drive(1'b0, '0);
        op(32'd2);

        // Strided back-to-back sweep across 0..1000000
        for (int i = 0; i <= 100; i++) op(32'(i * 10000));

        // Random traffic, including requests that land while busy
        for (int i = 0; i < 400; i++) begin
            logic [DWIDTH-1:0] d;
            d = ($urandom_range(0, 1) == 0) ? $urandom() : 32'($urandom_range(0, 200000000));
            drive($urandom_range(0, 2) == 0, d);
        end
        drive(1'b0, '0);

        // Drain with a bounded wait
        for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) check("drain_timeout", longint'(q.size()), 0);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
